// File: rtl/instr_sequencer.sv
// instr_sequencer: IDLE/DECODE/EXEC control FSM that decodes one 16-bit instruction per handshake
// and drives the alu/RegBank datapath selects, write enable and flag strobe.
module instr_sequencer #(
  parameter int REGS = 16,
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [3:0]      srcSel,
  output logic [3:0]      dstSel,
  output logic            regImmSel,
  output logic [15:0]     imm,
  output logic [7:0]      opcode,
  output logic [REGS-1:0] regEnable,
  output logic            flags_we,
  output logic            busy,
  output logic [15:0]     retired
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;
  state_t state, stateNext;
  logic [15:0] instrQ;
  logic accept, rType, sext, nop, noWrite;
  assign accept = state == IDLE && instr_valid;
  assign rType = instr[15:12] == 4'h0;
  assign sext = IMM_SEXT && (instr[15:12] == 4'h5 || instr[15:12] == 4'h9 || instr[15:12] == 4'hB);
  assign nop = instrQ == 16'h0000;
  // CMP and CMPI only update flags
  assign noWrite = (instrQ[15:12] == 4'h0 && instrQ[7:4] == 4'hB) || instrQ[15:12] == 4'hB;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state == IDLE ? (accept ? DECODE : IDLE) : state == DECODE ? EXEC : IDLE;
    instr_ready = state == IDLE;
    busy = !instr_ready;
    flags_we = state == EXEC && !nop;
    regEnable = '0;
    if (state == EXEC && !nop && !noWrite) regEnable = {{(REGS-1){1'b0}}, 1'b1} << instrQ[11:8];
  end
  // controls are decoded as the instruction is latched so they are stable for all of DECODE and EXEC
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      instrQ <= '0;
      srcSel <= '0;
      dstSel <= '0;
      regImmSel <= 1'b0;
      imm <= '0;
      opcode <= '0;
      retired <= '0;
    end else begin
      if (accept) begin
        instrQ <= instr;
        srcSel <= rType ? instr[3:0] : instr[11:8];
        dstSel <= instr[11:8];
        regImmSel <= !rType;
        imm <= rType ? 16'h0000 : sext ? {{8{instr[7]}}, instr[7:0]} : {8'h00, instr[7:0]};
        opcode <= rType ? {4'h0, instr[7:4]} : {instr[15:12], 4'h0};
      end
      if (state == EXEC) retired <= retired + 16'd1;
    end
endmodule
